// File: rtl/clk_mon_pkg.sv
// Shared constants for the divided-clock monitor: state encoding, code width and step.
package clk_mon_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned ST_W   = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_ACQ    = 2'd1;
  localparam logic [ST_W-1:0] ST_LOCKED = 2'd2;
  localparam logic [ST_W-1:0] ST_LOST   = 2'd3;

  localparam logic [CODE_W-1:0] CODE_STEP = 3'd1;

  // A good step is the previous code minus one, wrapping mod 2^CODE_W.
  function automatic logic step_ok(input logic [CODE_W-1:0] cur_code,
                                   input logic [CODE_W-1:0] prev_code);
    logic [CODE_W-1:0] want;
    want = CODE_W'(prev_code - CODE_STEP);
    return (cur_code == want);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear applies before the increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] base;

  always_comb begin
    base    = clr ? '0 : count_q;
    count_d = base;
    if (inc && (base != '1)) begin
      count_d = base + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/clk_monitor.sv
// Lock/error checker for the clk/2, clk/4, clk/8 divider outputs.
// Define CLK_MON_ERRCNT_EN to build the saturating error counter and its clear.
module clk_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned ERR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_ff,
  input  logic              clk_2ff,
  input  logic              clk_3ff,
  input  logic              err_clr,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [CODE_W-1:0] code
);

  localparam int unsigned CNT_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT - 1);

  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] prev_q, prev_d;
  logic [ST_W-1:0]   st_q, st_d;
  logic [CNT_W-1:0]  good_cnt_q, good_cnt_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic              step_good;

  // Sample pipeline: the newest code is judged against the one before it.
  always_comb begin
    code_d    = {clk_ff, clk_2ff, clk_3ff};
    prev_d    = code_q;
    step_good = step_ok(code_q, prev_q);
  end

  always_comb begin
    st_d        = st_q;
    good_cnt_d  = good_cnt_q;
    err_pulse_d = 1'b0;
    case (st_q)
      ST_IDLE: begin
        st_d = ST_ACQ;
      end
      ST_ACQ: begin
        if (!step_good) begin
          good_cnt_d = '0;
        end else if (good_cnt_q == LOCK_LAST) begin
          good_cnt_d = '0;
          st_d       = ST_LOCKED;
        end else begin
          good_cnt_d = good_cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (!step_good) begin
          err_pulse_d = 1'b1;
          st_d        = ST_LOST;
        end
      end
      ST_LOST: begin
        // The step out of a glitch is not judged; the bad code is the new reference.
        good_cnt_d = '0;
        st_d       = ST_ACQ;
      end
      default: begin
        good_cnt_d = '0;
        st_d       = ST_IDLE;
      end
    endcase
    locked_d = (st_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q      <= '0;
      prev_q      <= '0;
      st_q        <= ST_IDLE;
      good_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      code_q      <= code_d;
      prev_q      <= prev_d;
      st_q        <= st_d;
      good_cnt_q  <= good_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign code      = code_q;

`ifdef CLK_MON_ERRCNT_EN
  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_pulse_q),
    .clr   (err_clr),
    .count (err_count)
  );
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule
